// File: rtl/comma_aligner_if.sv
// Bus between the CDR sampler and the word aligner: serial bit in, framed
// 10-bit symbols plus framing status out.
interface comma_aligner_if;
    logic       Serial;
    logic [9:0] RxParallel_10;
    logic       WordValid;
    logic       CommaDet;
    logic       Aligned;
    logic       Realign;

    modport master (
        output Serial,
        input  RxParallel_10, WordValid, CommaDet, Aligned, Realign
    );

    modport slave (
        input  Serial,
        output RxParallel_10, WordValid, CommaDet, Aligned, Realign
    );
endinterface

// File: rtl/comma_aligner.sv
// K28.5 word aligner: deserialises the recovered bit stream and locks the
// 10-bit symbol boundary to commas, with lock/loss hysteresis.
module comma_aligner #(
    parameter int LOCK_COUNT = 3,
    parameter int LOSS_COUNT = 4
) (
    input  logic            BitCLK,
    input  logic            Reset,
    comma_aligner_if.slave  bus
);
    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

    localparam logic [3:0] LOCK_C = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_C = 4'(LOSS_COUNT);

    state_t      state, state_nxt;
    logic [9:0]  window_p0;
    logic [3:0]  cnt_p0;
    logic [3:0]  good, good_nxt, bad, bad_nxt;
    logic        comma, on_bnd, realign_nxt, emit;
    logic [9:0]  word_p1;
    logic        vld_p1, comma_p1, realign_p1;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    assign comma  = (window_p0 == 10'h17C) || (window_p0 == 10'h283);
    assign on_bnd = (cnt_p0 == 4'd9);

    always_comb begin
        state_nxt   = state;
        good_nxt    = good;
        bad_nxt     = bad;
        realign_nxt = 1'b0;
        if (comma) begin
            unique case (state)
                HUNT: begin
                    realign_nxt = !on_bnd;
                    good_nxt    = 4'd1;
                    if (LOCK_C == 4'd1) begin
                        state_nxt = LOCKED;
                        bad_nxt   = 4'd0;
                    end else begin
                        state_nxt = CHECK;
                    end
                end
                CHECK: begin
                    if (on_bnd) begin
                        good_nxt = sat_inc(good);
                        if (sat_inc(good) == LOCK_C) begin
                            state_nxt = LOCKED;
                            bad_nxt   = 4'd0;
                        end
                    end else begin
                        realign_nxt = 1'b1;
                        good_nxt    = 4'd1;
                    end
                end
                LOCKED: begin
                    if (on_bnd) begin
                        bad_nxt = 4'd0;
                    end else begin
                        bad_nxt = sat_inc(bad);
                        // Only a sustained run of misplaced commas moves a locked boundary
                        if (sat_inc(bad) == LOSS_C) begin
                            realign_nxt = 1'b1;
                            good_nxt    = 4'd1;
                            state_nxt   = CHECK;
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
        emit = on_bnd || realign_nxt;
    end

    // p0: shift window, phase counter and lock state
    always_ff @(posedge BitCLK or negedge Reset) begin
        if (!Reset) begin
            window_p0 <= '0;
            cnt_p0    <= '0;
            state     <= HUNT;
            good      <= '0;
            bad       <= '0;
        end else begin
            window_p0 <= {bus.Serial, window_p0[9:1]};
            cnt_p0    <= emit ? 4'd0 : cnt_p0 + 4'd1;
            state     <= state_nxt;
            good      <= good_nxt;
            bad       <= bad_nxt;
        end
    end

    // p1: framed word and its strobes
    always_ff @(posedge BitCLK or negedge Reset) begin
        if (!Reset) begin
            word_p1    <= '0;
            vld_p1     <= 1'b0;
            comma_p1   <= 1'b0;
            realign_p1 <= 1'b0;
        end else begin
            vld_p1     <= emit;
            comma_p1   <= emit && comma;
            realign_p1 <= realign_nxt;
            if (emit) word_p1 <= window_p0;
        end
    end

    assign bus.RxParallel_10 = word_p1;
    assign bus.WordValid     = vld_p1;
    assign bus.CommaDet      = comma_p1;
    assign bus.Realign       = realign_p1;
    assign bus.Aligned       = (state == LOCKED);
endmodule

// File: tb/tb_comma_aligner.sv
// Bench for comma_aligner: a default build and a LOCK_COUNT=1 build share one
// serial stream and are compared against a bit-history reference model.
module tb_comma_aligner;
    logic bit_clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    comma_aligner_if bus0 ();
    comma_aligner_if bus1 ();

    comma_aligner #(.LOCK_COUNT(3), .LOSS_COUNT(4)) dut0 (.BitCLK(bit_clk), .Reset(rst_n), .bus(bus0));
    comma_aligner #(.LOCK_COUNT(1), .LOSS_COUNT(4)) dut1 (.BitCLK(bit_clk), .Reset(rst_n), .bus(bus1));

    initial bit_clk = 1'b0;
    always #5 bit_clk = ~bit_clk;

    // Reference model: last ten bits, boundary origin edge, mode 0=hunt 1=check 2=locked
    int         edge_no;
    int         m_mode   [2];
    int         m_good   [2];
    int         m_bad    [2];
    int         m_origin [2];
    bit         m_hist   [2][10];
    logic [9:0] m_word   [2];
    bit         m_wv     [2];
    bit         m_cd     [2];
    bit         m_re     [2];

    typedef struct {
        logic [9:0] w;
        logic [9:0] exp_word;
        bit         exp_cd;
        bit         exp_al;
        bit         exp_re;
    } vec_t;
    vec_t tab [11];

    function automatic int lock_of(input int k);
        return (k == 0) ? 3 : 1;
    endfunction

    function automatic int loss_of(input int k);
        return (k == 0) ? 4 : 4;
    endfunction

    task automatic model_reset();
        edge_no = 0;
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_good[k] = 0; m_bad[k] = 0; m_origin[k] = 0;
            m_word[k] = '0; m_wv[k] = 0; m_cd[k] = 0; m_re[k] = 0;
            for (int i = 0; i < 10; i++) m_hist[k][i] = 0;
        end
    endtask

    task automatic model_edge(input int k, input bit b);
        logic [9:0] w;
        bit cm, onb, re;
        for (int i = 0; i < 10; i++) w[i] = m_hist[k][i];
        cm  = (w == 10'h17C) || (w == 10'h283);
        onb = ((edge_no - 1 - m_origin[k]) % 10) == 9;
        re  = 0;
        if (cm) begin
            if (m_mode[k] == 0) begin
                re = !onb;
                m_good[k] = 1;
                m_mode[k] = (lock_of(k) == 1) ? 2 : 1;
                if (m_mode[k] == 2) m_bad[k] = 0;
            end else if (m_mode[k] == 1) begin
                if (onb) begin
                    m_good[k] = (m_good[k] < 15) ? m_good[k] + 1 : 15;
                    if (m_good[k] == lock_of(k)) begin
                        m_mode[k] = 2;
                        m_bad[k] = 0;
                    end
                end else begin
                    re = 1;
                    m_good[k] = 1;
                end
            end else begin
                if (onb) m_bad[k] = 0;
                else begin
                    m_bad[k] = (m_bad[k] < 15) ? m_bad[k] + 1 : 15;
                    if (m_bad[k] == loss_of(k)) begin
                        re = 1;
                        m_good[k] = 1;
                        m_mode[k] = 1;
                    end
                end
            end
        end
        m_wv[k] = onb || re;
        if (m_wv[k]) m_word[k] = w;
        m_cd[k] = m_wv[k] && cm;
        m_re[k] = re;
        if (re) m_origin[k] = edge_no;
        for (int i = 0; i < 9; i++) m_hist[k][i] = m_hist[k][i+1];
        m_hist[k][9] = b;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h at edge %0d", name, act, exp, edge_no);
        end
    endtask

    function automatic void get_out(input int k, output logic [9:0] w, output logic wv,
                                    output logic cd, output logic al, output logic re);
        if (k == 0) begin
            w = bus0.RxParallel_10; wv = bus0.WordValid; cd = bus0.CommaDet;
            al = bus0.Aligned; re = bus0.Realign;
        end else begin
            w = bus1.RxParallel_10; wv = bus1.WordValid; cd = bus1.CommaDet;
            al = bus1.Aligned; re = bus1.Realign;
        end
    endfunction

    task automatic compare_model(input int k);
        logic [9:0] w;
        logic wv, cd, al, re;
        get_out(k, w, wv, cd, al, re);
        check($sformatf("model%0d_wordvalid", k), 32'(wv), 32'(m_wv[k]));
        check($sformatf("model%0d_word", k), 32'(w), 32'(m_word[k]));
        check($sformatf("model%0d_commadet", k), 32'(cd), 32'(m_cd[k]));
        check($sformatf("model%0d_aligned", k), 32'(al), 32'(m_mode[k] == 2));
        check($sformatf("model%0d_realign", k), 32'(re), 32'(m_re[k]));
    endtask

    task automatic tick(input bit b);
        bus0.Serial = b;
        bus1.Serial = b;
        @(posedge bit_clk);
        edge_no++;
        model_edge(0, b);
        model_edge(1, b);
        #1;
        compare_model(0);
        compare_model(1);
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_model(0);
        compare_model(1);
        @(posedge bit_clk);
        #1;
        compare_model(0);
        compare_model(1);
        @(negedge bit_clk);
        rst_n = 1'b1;
    endtask

    task automatic check_strobe(input int idx);
        logic [9:0] w;
        logic wv, cd, al, re;
        get_out(0, w, wv, cd, al, re);
        check($sformatf("tab%0d_wordvalid", idx), 32'(wv), 32'd1);
        check($sformatf("tab%0d_word", idx), 32'(w), 32'(tab[idx].exp_word));
        check($sformatf("tab%0d_commadet", idx), 32'(cd), 32'(tab[idx].exp_cd));
        check($sformatf("tab%0d_aligned", idx), 32'(al), 32'(tab[idx].exp_al));
        check($sformatf("tab%0d_realign", idx), 32'(re), 32'(tab[idx].exp_re));
    endtask

    task automatic idle_zeros(input int n, input string tag);
        logic [9:0] w;
        logic wv, cd, al, re;
        for (int i = 0; i < n; i++) begin
            tick(1'b0);
            get_out(0, w, wv, cd, al, re);
            check({tag, "_wordvalid"}, 32'(wv), 32'(edge_no % 10 == 0));
            check({tag, "_word"}, 32'(w), 32'd0);
            check({tag, "_aligned"}, 32'(al), 32'd0);
        end
    endtask

    initial begin
        logic [9:0] cw, w;
        logic wv, cd, al, re;
        int k, r, ns;
        bit b, stb;

        tab[0]  = '{10'h17C, 10'h17C, 1, 0, 1};
        tab[1]  = '{10'h17C, 10'h17C, 1, 0, 0};
        tab[2]  = '{10'h17C, 10'h17C, 1, 1, 0};
        tab[3]  = '{10'h2AA, 10'h2AA, 0, 1, 0};
        tab[4]  = '{10'h283, 10'h283, 1, 1, 0};
        tab[5]  = '{10'h2AA, 10'h2AA, 0, 1, 0};
        tab[6]  = '{10'h17C, 10'h17C, 1, 1, 0};
        tab[7]  = '{10'h2AA, 10'h2AA, 0, 1, 0};
        tab[8]  = '{10'h2AA, 10'h2AA, 0, 1, 0};
        tab[9]  = '{10'h283, 10'h283, 1, 1, 0};
        tab[10] = '{10'h17C, 10'h17C, 1, 1, 0};

        rst_n = 1'b0;
        bus0.Serial = 1'b0;
        bus1.Serial = 1'b0;
        model_reset();
        @(posedge bit_clk);
        #1;
        compare_model(0);
        compare_model(1);
        @(negedge bit_clk);
        rst_n = 1'b1;

        // Constant zero line: strobe every tenth edge, nothing else
        idle_zeros(30, "zeros");

        // Misphased preamble, three commas to lock, then locked traffic
        for (int i = 0; i < 3; i++) tick(1'($urandom_range(0, 1)));
        for (int i = 0; i < 11; i++) begin
            for (int j = 0; j < 10; j++) begin
                tick(tab[i].w[j]);
                if (j == 0 && i > 0) check_strobe(i - 1);
            end
        end

        // One slipped bit then six commas: loss after four, relock after two more
        tick(1'b0);
        check_strobe(10);
        cw = 10'h17C;
        for (int rr = 2; rr <= 62; rr++) begin
            b = (rr <= 61) ? cw[(rr - 2) % 10] : 1'b0;
            tick(b);
            stb = (rr == 11) || (rr == 21) || (rr == 31) || (rr == 41) ||
                  (rr == 42) || (rr == 52) || (rr == 62);
            get_out(0, w, wv, cd, al, re);
            check($sformatf("slip%0d_wordvalid", rr), 32'(wv), 32'(stb));
            if (stb) begin
                check($sformatf("slip%0d_word", rr), 32'(w), (rr <= 41) ? 32'h2F8 : 32'h17C);
                check($sformatf("slip%0d_commadet", rr), 32'(cd), 32'(rr >= 42));
                check($sformatf("slip%0d_realign", rr), 32'(re), 32'(rr == 42));
                check($sformatf("slip%0d_aligned", rr), 32'(al), 32'((rr <= 41) || (rr == 62)));
            end
        end

        // Reset mid-word while locked
        for (int i = 0; i < 4; i++) tick(1'b0);
        get_out(0, w, wv, cd, al, re);
        check("prereset_aligned", 32'(al), 32'd1);
        async_reset();
        idle_zeros(30, "postreset");

        // Single RD+ comma at an arbitrary phase: the LOCK_COUNT=1 build locks on it
        k = $urandom_range(1, 8);
        cw = 10'h283;
        for (int i = 0; i < k; i++) tick(1'b0);
        for (int j = 0; j < 10; j++) tick(cw[j]);
        get_out(1, w, wv, cd, al, re);
        check("single_pre_aligned", 32'(al), 32'd0);
        tick(1'b0);
        get_out(1, w, wv, cd, al, re);
        check("single_wordvalid", 32'(wv), 32'd1);
        check("single_word", 32'(w), 32'h283);
        check("single_realign", 32'(re), 32'd1);
        check("single_aligned", 32'(al), 32'd1);
        for (int i = 0; i < 12; i++) tick(1'b0);

        // Random words, commas of both disparities, bit slips and resets
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) async_reset();
            if ($urandom_range(0, 7) == 0) begin
                ns = $urandom_range(1, 3);
                for (int s = 0; s < ns; s++) tick(1'($urandom_range(0, 1)));
            end
            r = $urandom_range(0, 9);
            if (r < 4)       w = r[0] ? 10'h17C : 10'h283;
            else if (r == 4) w = 10'h2AA;
            else             w = 10'($urandom_range(0, 1023));
            for (int j = 0; j < 10; j++) tick(w[j]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
